// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: self-timed sample ticks, 2-of-3 mid-bit voting,
// runtime frame format, valid/ready holding register with overrun and break reporting.
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int UART_SIZE  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [3:0]           data_len,
  input  logic                 parity_enable,
  input  logic                 parity_type,
  input  logic                 stop_bits,
  output logic [UART_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 overrun,
  output logic                 break_detect,
  output logic                 busy
);
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0] SC_S0   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_S1   = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_DEC  = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]      MAX_LEN = 4'(UART_SIZE);
  localparam logic [3:0]      MIN_LEN = 4'd5;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t                 state_reg;
  logic                   rx_meta_reg, rx_sync_reg;
  logic [DIV_WIDTH-1:0]   div_cnt_reg, div_reg;
  logic [SC_W-1:0]        sc_reg, sc_adv;
  logic [3:0]             len_reg, len_eff, bit_cnt_reg;
  logic                   pe_reg, pt_reg, sb_reg, stop_cnt_reg, pbit_reg, serr_reg;
  logic                   samp0_reg, samp1_reg;
  logic [UART_SIZE-1:0]   shift_reg, bit_sel;
  logic                   tick, decide, maj, serr_new, perr_new, break_cond;

  assign tick       = (div_cnt_reg == '0);
  assign sc_adv     = (sc_reg == SC_LAST) ? '0 : sc_reg + SC_W'(1);
  assign decide     = tick && (sc_adv == SC_DEC) && (state_reg != IDLE) && (state_reg != BREAK_WAIT);
  assign maj        = (samp0_reg & samp1_reg) | (samp0_reg & rx_sync_reg) | (samp1_reg & rx_sync_reg);
  assign len_eff    = (data_len < MIN_LEN || data_len > MAX_LEN) ? MAX_LEN : data_len;
  assign serr_new   = serr_reg | ~maj;
  // XOR of data and parity bit is 1 for an odd count of ones; even mode wants 0
  assign perr_new   = pe_reg & (^shift_reg ^ pbit_reg ^ ~pt_reg);
  assign break_cond = ~stop_cnt_reg & ~maj & (shift_reg == '0) & ~(pe_reg & pbit_reg);
  assign busy       = (state_reg != IDLE);

  generate
    for (genvar gi = 0; gi < UART_SIZE; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_cnt_reg == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Free-running in IDLE on the live divisor; frame-locked to the captured one otherwise
  always_ff @(posedge clk) begin
    if (!reset)
      div_cnt_reg <= '0;
    else if (tick)
      div_cnt_reg <= (state_reg == IDLE) ? baud_div : div_reg;
    else
      div_cnt_reg <= div_cnt_reg - DIV_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      sc_reg       <= '0;
      div_reg      <= '0;
      len_reg      <= MAX_LEN;
      bit_cnt_reg  <= '0;
      pe_reg       <= 1'b0;
      pt_reg       <= 1'b0;
      sb_reg       <= 1'b0;
      stop_cnt_reg <= 1'b0;
      pbit_reg     <= 1'b0;
      serr_reg     <= 1'b0;
      samp0_reg    <= 1'b1;
      samp1_reg    <= 1'b1;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      overrun      <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      overrun      <= 1'b0;
      break_detect <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      if (tick && state_reg != IDLE && state_reg != BREAK_WAIT) begin
        sc_reg <= sc_adv;
        if (sc_adv == SC_S0) samp0_reg <= rx_sync_reg;
        if (sc_adv == SC_S1) samp1_reg <= rx_sync_reg;
      end
      case (state_reg)
        IDLE: begin
          if (tick && !rx_sync_reg) begin
            state_reg    <= START;
            sc_reg       <= '0;
            div_reg      <= baud_div;
            len_reg      <= len_eff;
            pe_reg       <= parity_enable;
            pt_reg       <= parity_type;
            sb_reg       <= stop_bits;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            pbit_reg     <= 1'b0;
            serr_reg     <= 1'b0;
            shift_reg    <= '0;
          end
        end
        START: begin
          if (decide)
            state_reg <= maj ? IDLE : DATA;
        end
        DATA: begin
          if (decide) begin
            shift_reg <= (shift_reg & ~bit_sel) | (bit_sel & {UART_SIZE{maj}});
            if (bit_cnt_reg == len_reg - 4'd1)
              state_reg <= pe_reg ? PARITY : STOP;
            else
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
        end
        PARITY: begin
          if (decide) begin
            pbit_reg  <= maj;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (break_cond) begin
              break_detect <= 1'b1;
              state_reg    <= BREAK_WAIT;
            end else if (sb_reg && !stop_cnt_reg) begin
              stop_cnt_reg <= 1'b1;
              serr_reg     <= serr_new;
            end else begin
              // A simultaneous handshake frees the register for this frame
              if (!rx_valid || rx_ready) begin
                rx_data      <= shift_reg;
                parity_error <= perr_new;
                stop_error   <= serr_new;
                rx_valid     <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state_reg <= IDLE;
            end
          end
        end
        BREAK_WAIT: begin
          if (tick && rx_sync_reg)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: a frame-level model predicts each delivered word,
// overrun and break; a per-cycle monitor checks the DUT against it.
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        reset_n, rx_line;
  logic [15:0] baud_div;
  logic [3:0]  data_len;
  logic        parity_enable, parity_type, stop_bits, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_error, stop_error, overrun, break_detect, busy;

  always #5 clk = ~clk;

  uart_rx_os #(.UART_SIZE(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset_n), .RX(rx_line), .baud_div(baud_div),
    .data_len(data_len), .parity_enable(parity_enable), .parity_type(parity_type),
    .stop_bits(stop_bits), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_error(parity_error), .stop_error(stop_error), .overrun(overrun),
    .break_detect(break_detect), .busy(busy)
  );

  typedef struct { logic [7:0] data; logic perr; logic serr; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0, n_fail = 0;
  int hs_count = 0, obs_ovr = 0, obs_brk = 0, exp_ovr = 0, exp_brk = 0;
  bit held_model = 0;
  logic [7:0] last_data = '0;
  logic last_perr = 0, last_serr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int eff_len();
    return (data_len < 4'd5 || data_len > 4'd8) ? 8 : int'(data_len);
  endfunction

  // Frame semantics from the line bits: count ones for parity, any zero stop is an error
  function automatic void model_frame(input logic [7:0] data, input logic pbit,
                                      input logic stop1, input logic stop2,
                                      output exp_t e, output bit brk);
    int ones = 0;
    logic [7:0] d = '0;
    for (int i = 0; i < eff_len(); i++) begin
      d[i] = data[i];
      ones += int'(data[i]);
    end
    if (parity_enable) ones += int'(pbit);
    e.data = d;
    e.perr = parity_enable && (parity_type ? (ones % 2 == 1) : (ones % 2 == 0));
    e.serr = !stop1 || (stop_bits && !stop2);
    brk    = (d == 8'h00) && (!parity_enable || !pbit) && !stop1;
  endfunction

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit,
                            input logic stop1, input logic stop2);
    exp_t e;
    bit brk;
    model_frame(data, pbit, stop1, stop2, e, brk);
    if (brk) exp_brk++;
    else if (held_model && !rx_ready) exp_ovr++;
    else begin
      exp_q.push_back(e);
      if (!rx_ready) held_model = 1;
    end
    send_bit(1'b0);
    for (int i = 0; i < eff_len(); i++) send_bit(data[i]);
    if (parity_enable) send_bit(pbit);
    send_bit(stop1);
    if (stop_bits) send_bit(stop2);
    send_bit(1'b1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic se, input int h0);
    check({name, "_handshakes"}, hs_count, h0 + 1);
    check({name, "_data"}, last_data, d);
    check({name, "_perr"}, last_perr, pe);
    check({name, "_serr"}, last_serr, se);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rx_data"}, rx_data, 0);
    check({name, "_rx_valid"}, rx_valid, 0);
    check({name, "_parity_error"}, parity_error, 0);
    check({name, "_stop_error"}, stop_error, 0);
    check({name, "_overrun"}, overrun, 0);
    check({name, "_break_detect"}, break_detect, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  // Per-cycle monitor
  initial begin : monitor
    exp_t e;
    logic prev_valid = 0, prev_ready = 0, prev_ovr = 0, prev_brk = 0;
    logic [9:0] prev_word = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (prev_valid && !prev_ready) begin
          check("hold_valid", rx_valid, 1);
          check("hold_word", {rx_data, parity_error, stop_error}, prev_word);
        end
        if (rx_valid && rx_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, required no word", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("word_data", rx_data, e.data);
            check("word_perr", parity_error, e.perr);
            check("word_serr", stop_error, e.serr);
          end
          last_data = rx_data;
          last_perr = parity_error;
          last_serr = stop_error;
        end
        if (overrun) begin
          obs_ovr++;
          check("overrun_width", prev_ovr, 0);
        end
        if (break_detect) begin
          obs_brk++;
          check("break_width", prev_brk, 0);
        end
        prev_valid = rx_valid;
      end else begin
        prev_valid = 1'b0;
      end
      prev_ready = rx_ready;
      prev_ovr   = overrun;
      prev_brk   = break_detect;
      prev_word  = {rx_data, parity_error, stop_error};
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int h0;
    exp_t e;
    bit brk;
    reset_n = 1'b0; rx_line = 1'b1; baud_div = 16'd3; data_len = 4'd8;
    parity_enable = 0; parity_type = 0; stop_bits = 0; rx_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;

    // 8N1
    h0 = hs_count; send_frame(8'h65, 0, 1, 1); check_frame("8n1_65", 8'h65, 0, 0, h0);

    // 7E1: wrong then correct parity
    data_len = 4'd7; parity_enable = 1; parity_type = 1;
    h0 = hs_count; send_frame(8'h2A, 0, 1, 1); check_frame("7e1_bad", 8'h2A, 1, 0, h0);
    h0 = hs_count; send_frame(8'h2A, 1, 1, 1); check_frame("7e1_good", 8'h2A, 0, 0, h0);

    // 8N2: bad second stop, then clean
    data_len = 4'd8; parity_enable = 0; parity_type = 0; stop_bits = 1;
    h0 = hs_count; send_frame(8'hC3, 0, 1, 0); check_frame("8n2_bad", 8'hC3, 0, 1, h0);
    h0 = hs_count; send_frame(8'h5A, 0, 1, 1); check_frame("8n2_good", 8'h5A, 0, 0, h0);

    // Out-of-range length falls back to the full width
    stop_bits = 0; data_len = 4'd15;
    h0 = hs_count; send_frame(8'h96, 0, 1, 1); check_frame("len15", 8'h96, 0, 0, h0);
    data_len = 4'd8;

    // Glitch shorter than half a bit
    h0 = hs_count;
    rx_line = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_busy_rises", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (BIT_CLKS - 16) @(posedge clk);
    #1;
    check("glitch_busy_clear", busy, 0);
    check("glitch_no_word", hs_count, h0);
    h0 = hs_count; send_frame(8'h11, 0, 1, 1); check_frame("after_glitch", 8'h11, 0, 0, h0);

    // Overrun with consumer stalled
    rx_ready = 0;
    send_frame(8'hA5, 0, 1, 1);
    send_frame(8'h3C, 0, 1, 1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'hA5);
    check("ovr_count", obs_ovr, 1);

    // Break: 20 bit times low
    model_frame(8'h00, 0, 0, 0, e, brk);
    check("model_break", brk, 1);
    exp_brk++;
    rx_line = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    check("brk_count", obs_brk, 1);
    check("brk_data_kept", rx_data, 8'hA5);
    check("brk_valid_kept", rx_valid, 1);

    h0 = hs_count;
    rx_ready = 1; held_model = 0;
    repeat (2) @(posedge clk);
    #1;
    check_frame("drain_a5", 8'hA5, 0, 0, h0);
    check("drain_valid_low", rx_valid, 0);
    h0 = hs_count; send_frame(8'h01, 0, 1, 1); check_frame("after_break", 8'h01, 0, 0, h0);

    // Reset in data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_line = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_outputs_zero("midframe_reset");
    repeat (10 * BIT_CLKS) @(posedge clk);
    #1;
    h0 = hs_count; send_frame(8'h81, 0, 1, 1); check_frame("after_reset", 8'h81, 0, 0, h0);

    repeat (BIT_CLKS) @(posedge clk);
    #1;
    check("pending_words", exp_q.size(), 0);
    check("total_overruns", obs_ovr, exp_ovr);
    check("total_breaks", obs_brk, exp_brk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
